// File: rtl/serial_link_pkg.sv
// Shared definitions for the shift-data/latch serial link (transmit drivers and receiver).
package serial_link_pkg;

  localparam int unsigned SL_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FULL  = 2'd2,
    S_ERR   = 2'd3
  } sl_state_e;

endpackage

// File: rtl/sig_edge_det.sv
// One-bit history register with a combinational rising-edge pulse.
module sig_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_c = d_i & ~d_q;

endmodule

// File: rtl/serial_latch_rx.sv
// Serial shift/latch link receiver: deserializes WIDTH-bit frames onto a valid/accept handshake.
// Define SERIAL_LATCH_RX_SYNC_EN to add 2-flop synchronizers on i_sclk, i_sdata and i_latch.
module serial_latch_rx
  import serial_link_pkg::*;
#(
  parameter int unsigned WIDTH     = SL_WIDTH_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sclk,
  input  logic             i_sdata,
  input  logic             i_latch,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_accept,
  output logic             o_frame_err,
  output logic             o_overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic sclk_s, sdata_s, latch_s;
  logic sclk_rise_c, latch_rise_c;

`ifdef SERIAL_LATCH_RX_SYNC_EN
  // sdata shares the sclk pipeline depth so data/clock alignment is preserved
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {i_latch, i_sdata, i_sclk};
      sync2_q <= sync1_q;
    end
  end

  assign {latch_s, sdata_s, sclk_s} = sync2_q;
`else
  assign {latch_s, sdata_s, sclk_s} = {i_latch, i_sdata, i_sclk};
`endif

  sig_edge_det u_sclk_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk_s),
    .rise_c (sclk_rise_c)
  );

  sig_edge_det u_latch_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (latch_s),
    .rise_c (latch_rise_c)
  );

  sl_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  // Next-state: latch has priority over a coincident sclk edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (valid_q && i_accept) begin
      valid_d = 1'b0;
    end

    if (latch_rise_c) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      if (state_q == S_FULL) begin
        if (!valid_q || i_accept) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        ferr_d = 1'b1;
      end
    end else if (sclk_rise_c) begin
      case (state_q)
        S_IDLE, S_SHIFT: begin
          if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], sdata_s};
          end else begin
            shreg_d = {sdata_s, shreg_q[WIDTH-1:1]};
          end
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? S_FULL : S_SHIFT;
        end
        S_FULL:  state_d = S_ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_serial_latch_rx.sv
// Self-checking bench for serial_latch_rx: MSB-first and LSB-first instances driven in parallel.
module tb_serial_latch_rx;

  localparam int unsigned W = 16;
`ifdef SERIAL_LATCH_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sclk = 1'b0, sdata = 1'b0, latch = 1'b0, accept = 1'b0;
  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor-owned observation history (only written here)
  logic [W-1:0] got_m[$];
  logic [W-1:0] got_l[$];
  int ferr_cnt_m = 0, ferr_cnt_l = 0, vcyc = 0;

  always #5 clk = ~clk;

  serial_latch_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .i_sclk(sclk), .i_sdata(sdata), .i_latch(latch),
    .o_data(data_m), .o_valid(valid_m), .i_accept(accept),
    .o_frame_err(ferr_m), .o_overrun(ovr_m)
  );

  serial_latch_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .i_sclk(sclk), .i_sdata(sdata), .i_latch(latch),
    .o_data(data_l), .o_valid(valid_l), .i_accept(accept),
    .o_frame_err(ferr_l), .o_overrun(ovr_l)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_m && accept) got_m.push_back(data_m);
      if (valid_l && accept) got_l.push_back(data_l);
      if (ferr_m) ferr_cnt_m++;
      if (ferr_l) ferr_cnt_l++;
      if (valid_m) vcyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = x[int'(W) - 1 - i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shift out the low n bits of word, highest first; 4 clk per sclk period
  task automatic send_bits(input logic [31:0] word, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdata = word[i];
      sclk  = 1'b0;
      tick(2);
      sclk  = 1'b1;
      tick(2);
    end
    sclk = 1'b0;
    tick(2);
  endtask

  task automatic do_latch();
    latch = 1'b1;
    tick(4);
    latch = 1'b0;
    tick(4 + SYNC_LAT);
  endtask

  task automatic do_reset(input int n);
    sclk = 1'b0; sdata = 1'b0; latch = 1'b0;
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
    tick(1);
  endtask

  typedef struct {
    logic [31:0]  word;
    int           nbits;
    bit           acc;
    logic [W-1:0] exp_data;
    bit           exp_valid;
    int           exp_ferr;
    bit           exp_ovr;
    int           exp_deliv;
    int           exp_vcyc;   // -1: not checked
  } vec_t;

  vec_t tbl[6];

  initial begin
    int b_got, b_ferr, b_ferr_l, b_vcyc;
    logic [W-1:0] exp_q[$];
    int ferr_exp;

    tbl[0] = '{32'hA5C3, 16, 1'b1, 16'hA5C3, 1'b0, 0, 1'b0, 1, 1};
    tbl[1] = '{32'h1234, 15, 1'b1, 16'hA5C3, 1'b0, 1, 1'b0, 0, 0};
    tbl[2] = '{32'h1234, 16, 1'b1, 16'h1234, 1'b0, 0, 1'b0, 1, 1};
    tbl[3] = '{32'h00FF, 16, 1'b0, 16'h00FF, 1'b1, 0, 1'b0, 0, -1};
    tbl[4] = '{32'hFF00, 16, 1'b0, 16'h00FF, 1'b1, 0, 1'b1, 0, -1};
    tbl[5] = '{32'h1ABCD, 17, 1'b0, 16'h00FF, 1'b1, 1, 1'b1, 0, -1};

    // Reset with toggling inputs
    for (int i = 0; i < 3; i++) begin
      sclk = 1'($urandom); sdata = 1'($urandom); latch = 1'($urandom); accept = 1'($urandom);
      tick(1);
    end
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_data", 32'(data_m), 32'd0);
    chk("rst_ferr", 32'(ferr_m), 32'd0);
    chk("rst_ovr", 32'(ovr_m), 32'd0);
    chk("rst_data_lsb", 32'(data_l), 32'd0);
    chk("rst_valid_lsb", 32'(valid_l), 32'd0);
    do_reset(1);
    chk("rst_release_ferr", 32'(ferr_cnt_m), 32'd0);

    // Table-driven frames
    for (int r = 0; r < 6; r++) begin
      b_got = got_m.size(); b_ferr = ferr_cnt_m; b_ferr_l = ferr_cnt_l; b_vcyc = vcyc;
      accept = tbl[r].acc;
      send_bits(tbl[r].word, tbl[r].nbits);
      do_latch();
      chk($sformatf("row%0d_valid", r), 32'(valid_m), 32'(tbl[r].exp_valid));
      chk($sformatf("row%0d_valid_lsb", r), 32'(valid_l), 32'(tbl[r].exp_valid));
      chk($sformatf("row%0d_data", r), 32'(data_m), 32'(tbl[r].exp_data));
      chk($sformatf("row%0d_data_lsb", r), 32'(data_l), 32'(bitrev(tbl[r].exp_data)));
      chk($sformatf("row%0d_ferr", r), 32'(ferr_cnt_m - b_ferr), 32'(tbl[r].exp_ferr));
      chk($sformatf("row%0d_ferr_lsb", r), 32'(ferr_cnt_l - b_ferr_l), 32'(tbl[r].exp_ferr));
      chk($sformatf("row%0d_ovr", r), 32'(ovr_m), 32'(tbl[r].exp_ovr));
      chk($sformatf("row%0d_ovr_lsb", r), 32'(ovr_l), 32'(tbl[r].exp_ovr));
      chk($sformatf("row%0d_deliv", r), 32'(got_m.size() - b_got), 32'(tbl[r].exp_deliv));
      for (int k = b_got; k < got_m.size(); k++)
        chk($sformatf("row%0d_deliv_val", r), 32'(got_m[k]), 32'(tbl[r].exp_data));
      if (tbl[r].exp_vcyc >= 0)
        chk($sformatf("row%0d_vcyc", r), 32'(vcyc - b_vcyc), 32'(tbl[r].exp_vcyc));
    end

    // Accept pending overrun frame: o_valid drops the next cycle
    accept = 1'b1;
    chk("acc_before", 32'(valid_m), 32'd1);
    tick(1);
    accept = 1'b0;
    chk("acc_after", 32'(valid_m), 32'd0);
    chk("acc_ovr_sticky", 32'(ovr_m), 32'd1);
    do_reset(2);
    chk("ovr_cleared", 32'(ovr_m), 32'd0);

    // Commit and accept in the same cycle
    accept = 1'b0;
    send_bits(32'h1111, 16);
    do_latch();
    chk("cc_first_valid", 32'(valid_m), 32'd1);
    chk("cc_first_data", 32'(data_m), 32'h1111);
    b_got = got_m.size();
    send_bits(32'h2222, 16);
    latch = 1'b1;
    tick(SYNC_LAT);
    accept = 1'b1;
    tick(1);
    accept = 1'b0;
    tick(3);
    latch = 1'b0;
    tick(3);
    chk("cc_valid", 32'(valid_m), 32'd1);
    chk("cc_data", 32'(data_m), 32'h2222);
    chk("cc_ovr", 32'(ovr_m), 32'd0);
    chk("cc_deliv", 32'(got_m.size() - b_got), 32'd1);
    if (got_m.size() > b_got) chk("cc_deliv_val", 32'(got_m[b_got]), 32'h1111);
    accept = 1'b1;
    tick(2);
    accept = 1'b0;

    // Reset mid-frame, then a clean frame
    send_bits(32'hAB, 8);
    do_reset(2);
    b_got = got_m.size(); b_ferr = ferr_cnt_m;
    accept = 1'b1;
    send_bits(32'hBEEF, 16);
    do_latch();
    chk("midrst_deliv", 32'(got_m.size() - b_got), 32'd1);
    if (got_m.size() > b_got) chk("midrst_val", 32'(got_m[b_got]), 32'hBEEF);
    chk("midrst_data_lsb", 32'(data_l), 32'(bitrev(16'hBEEF)));
    chk("midrst_ferr", 32'(ferr_cnt_m - b_ferr), 32'd0);

    // Coincident sclk and latch rise: latch wins, extra edge discarded
    b_got = got_m.size(); b_ferr = ferr_cnt_m;
    send_bits(32'h0F0F, 16);
    sdata = 1'b1; sclk = 1'b1; latch = 1'b1;
    tick(4);
    sclk = 1'b0; latch = 1'b0;
    tick(4 + SYNC_LAT);
    chk("coinc_deliv", 32'(got_m.size() - b_got), 32'd1);
    if (got_m.size() > b_got) chk("coinc_val", 32'(got_m[b_got]), 32'h0F0F);
    chk("coinc_ferr", 32'(ferr_cnt_m - b_ferr), 32'd0);

    // Randomized frames against a frame-level model
    b_got = got_m.size(); b_ferr = ferr_cnt_m;
    ferr_exp = 0;
    accept = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int unsigned sel;
      int n;
      logic [31:0] w;
      sel = $urandom_range(0, 7);
      n = (sel == 0) ? 15 : (sel == 1) ? 17 : (sel == 2) ? 0 : 16;
      w = $urandom;
      send_bits(w, n);
      do_latch();
      tick($urandom_range(0, 3));
      if (n == int'(W)) exp_q.push_back(w[W-1:0]);
      else ferr_exp++;
    end
    tick(10);
    chk("rand_count", 32'(got_m.size() - b_got), 32'(exp_q.size()));
    chk("rand_count_lsb", 32'(got_l.size() - b_got), 32'(exp_q.size()));
    chk("rand_ferr", 32'(ferr_cnt_m - b_ferr), 32'(ferr_exp));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (b_got + k < got_m.size())
        chk($sformatf("rand_val%0d", k), 32'(got_m[b_got + k]), 32'(exp_q[k]));
      if (b_got + k < got_l.size())
        chk($sformatf("rand_lsb%0d", k), 32'(got_l[b_got + k]), 32'(bitrev(exp_q[k])));
    end
    chk("rand_ovr", 32'(ovr_m), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
